// File: rtl/mux_scan.sv
// Registered N:1 multiplexer with manual select and a dwell-timed round-robin scan mode.
// Outputs carry the source channel tag, a channel-change strobe and an out-of-range flag.
module mux_scan #(
  parameter int unsigned N     = 5,
  parameter int unsigned W     = 1,
  parameter int unsigned SW    = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din_i,
  input  logic [SW-1:0]   sel_i,
  input  logic            mode_i,
  input  logic            en_i,
  output logic [W-1:0]    m_o,
  output logic [SW-1:0]   m_ch_o,
  output logic            m_valid_o,
  output logic            err_o
);

  localparam int unsigned DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {StNone, StMan, StScan} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [W-1:0]    m_q, m_d;
  logic [SW-1:0]   m_ch_q, m_ch_d;
  logic            m_valid_q, m_valid_d;
  logic            err_q, err_d;

  logic            entry;
  logic            sel_ok;
  logic [SW-1:0]   ec;
  logic [SW-1:0]   idx;
  logic [W-1:0]    din_sel;
  logic [DW-1:0]   cnt;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dcnt_d    = dcnt_q;
    m_d       = m_q;
    m_ch_d    = m_ch_q;
    m_valid_d = 1'b0;
    err_d     = err_q;

    // Scan entry restarts from channel 0 with a fresh dwell count
    entry  = (state_q != StScan);
    ec     = entry ? '0 : ch_q;
    idx    = mode_i ? ec : sel_i;
    sel_ok = (32'(sel_i) < N);
    cnt    = (entry ? '0 : dcnt_q) + DW'(1);

    din_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) din_sel = din_i[k*W +: W];
    end

    if (en_i) begin
      if (!mode_i) begin
        state_d = StMan;
        if (sel_ok) begin
          m_d       = din_sel;
          m_ch_d    = sel_i;
          err_d     = 1'b0;
          m_valid_d = (state_q == StNone) || (sel_i != m_ch_q);
        end else begin
          err_d = 1'b1;
        end
      end else begin
        state_d   = StScan;
        m_d       = din_sel;
        m_ch_d    = ec;
        err_d     = 1'b0;
        m_valid_d = (state_q == StNone) || (ec != m_ch_q);
        if (cnt == DW'(DWELL)) begin
          ch_d   = (ec == SW'(N - 1)) ? '0 : ec + SW'(1);
          dcnt_d = '0;
        end else begin
          ch_d   = ec;
          dcnt_d = cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StNone;
      ch_q      <= '0;
      dcnt_q    <= '0;
      m_q       <= '0;
      m_ch_q    <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dcnt_q    <= dcnt_d;
      m_q       <= m_d;
      m_ch_q    <= m_ch_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  assign m_o       = m_q;
  assign m_ch_o    = m_ch_q;
  assign m_valid_o = m_valid_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: two instances (DWELL 2 and DWELL 4) share one stimulus stream.
module tb_mux_scan;

  localparam logic [19:0] DinBase = 20'hFC53A;  // channels 4..0 = F,C,5,3,A
  localparam logic [19:0] DinCh37 = 20'hF753A;  // channel 3 changed to 7

  logic        clk;
  logic        rst_n;
  logic [19:0] din;
  logic [2:0]  sel;
  logic        mode;
  logic        en;

  logic [3:0]  m2, m4;
  logic [2:0]  ch2, ch4;
  logic        v2, v4, e2, e4;

  int n_vec;
  int n_err;

  mux_scan #(.N(5), .W(4), .SW(3), .DWELL(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_i     (din),
    .sel_i     (sel),
    .mode_i    (mode),
    .en_i      (en),
    .m_o       (m2),
    .m_ch_o    (ch2),
    .m_valid_o (v2),
    .err_o     (e2)
  );

  mux_scan #(.N(5), .W(4), .SW(3), .DWELL(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_i     (din),
    .sel_i     (sel),
    .mode_i    (mode),
    .en_i      (en),
    .m_o       (m4),
    .m_ch_o    (ch4),
    .m_valid_o (v4),
    .err_o     (e4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] din;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  m;
    logic [2:0]  ch;
    logic        v;
    logic        e;
    logic        both;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [19:0] d, input logic en_v, input logic mode_v,
                     input logic [2:0] sel_v, input logic [3:0] m_v, input logic [2:0] ch_v,
                     input logic v_v, input logic e_v, input logic both_v);
    vec_t t;
    t.din = d; t.en = en_v; t.mode = mode_v; t.sel = sel_v;
    t.m = m_v; t.ch = ch_v; t.v = v_v; t.e = e_v; t.both = both_v;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [3:0] am, input logic [2:0] ach,
                     input logic av, input logic ae, input logic [3:0] xm,
                     input logic [2:0] xch, input logic xv, input logic xe);
    n_vec++;
    if (am !== xm || ach !== xch || av !== xv || ae !== xe) begin
      n_err++;
      $display("FAIL %s: got m=%h ch=%0d valid=%b err=%b, want m=%h ch=%0d valid=%b err=%b",
               name, am, ach, av, ae, xm, xch, xv, xe);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges and confirm outputs clear without a clock edge
  task automatic async_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, "_rst2"}, m2, ch2, v2, e2, 4'h0, 3'd0, 1'b0, 1'b0);
    chk({name, "_rst4"}, m4, ch4, v4, e4, 4'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    din   = DinBase;
    sel   = 3'd0;
    mode  = 1'b0;
    en    = 1'b0;

    // Scan DWELL=2 from reset (only the DWELL=2 instance is checked here)
    add(DinBase, 1, 1, 0, 4'hA, 0, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'hA, 0, 0, 0, 0);
    add(DinBase, 1, 1, 0, 4'h3, 1, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'h3, 1, 0, 0, 0);
    add(DinBase, 1, 1, 0, 4'h5, 2, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'h5, 2, 0, 0, 0);
    add(DinBase, 1, 1, 0, 4'hC, 3, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'hC, 3, 0, 0, 0);
    add(DinBase, 1, 1, 0, 4'hF, 4, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'hF, 4, 0, 0, 0);
    add(DinBase, 1, 1, 0, 4'hA, 0, 1, 0, 0);
    add(DinBase, 1, 1, 0, 4'hA, 0, 0, 0, 0);
    // Manual select, hold, live data change, out-of-range, recovery (both instances)
    add(DinBase, 1, 0, 3, 4'hC, 3, 1, 0, 1);
    add(DinBase, 1, 0, 3, 4'hC, 3, 0, 0, 1);
    add(DinBase, 1, 0, 3, 4'hC, 3, 0, 0, 1);
    add(DinCh37, 1, 0, 3, 4'h7, 3, 0, 0, 1);
    add(DinBase, 1, 0, 5, 4'h7, 3, 0, 1, 1);
    add(DinBase, 1, 0, 7, 4'h7, 3, 0, 1, 1);
    add(DinBase, 1, 0, 0, 4'hA, 0, 1, 0, 1);

    step();
    chk("reset2", m2, ch2, v2, e2, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("reset4", m4, ch4, v4, e4, 4'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      din  = tbl[i].din;
      en   = tbl[i].en;
      mode = tbl[i].mode;
      sel  = tbl[i].sel;
      step();
      chk($sformatf("vec%0d_d2", i), m2, ch2, v2, e2, tbl[i].m, tbl[i].ch, tbl[i].v, tbl[i].e);
      if (tbl[i].both)
        chk($sformatf("vec%0d_d4", i), m4, ch4, v4, e4, tbl[i].m, tbl[i].ch, tbl[i].v, tbl[i].e);
    end

    // Freeze mid-dwell on DWELL=4: 4x ch0, 2x ch1, freeze 3, then 2x ch1 and ch2
    din = DinBase;
    async_reset("frz");
    mode = 1'b1;
    en   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("frz_run%0d", k), m4, ch4, v4, e4, (k < 4) ? 4'hA : 4'h3,
          (k < 4) ? 3'd0 : 3'd1, (k == 0 || k == 4), 1'b0);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("frz_hold%0d", k), m4, ch4, v4, e4, 4'h3, 3'd1, 1'b0, 1'b0);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("frz_resume%0d", k), m4, ch4, v4, e4, (k < 2) ? 4'h3 : 4'h5,
          (k < 2) ? 3'd1 : 3'd2, (k == 2), 1'b0);
    end

    // Mode switch: manual ch4, then scan restarts at ch0 for a full dwell, then manual ch2
    mode = 1'b0;
    sel  = 3'd4;
    step();
    chk("sw_man4", m4, ch4, v4, e4, 4'hF, 3'd4, 1'b1, 1'b0);
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sw_scan%0d", k), m4, ch4, v4, e4, (k < 4) ? 4'hA : 4'h3,
          (k < 4) ? 3'd0 : 3'd1, (k == 0 || k == 4), 1'b0);
    end
    mode = 1'b0;
    sel  = 3'd2;
    step();
    chk("sw_man2", m4, ch4, v4, e4, 4'h5, 3'd2, 1'b1, 1'b0);

    // Async reset mid-scan, release with scan enabled
    mode = 1'b1;
    step();
    step();
    async_reset("ar");
    step();
    chk("ar_first2", m2, ch2, v2, e2, 4'hA, 3'd0, 1'b1, 1'b0);
    chk("ar_first4", m4, ch4, v4, e4, 4'hA, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
